// File: rtl/note_pkg.sv
// Shared constants, lane indices, FSM encoding and saturating helpers
// for the note scroller rhythm-game core.
package note_pkg;

    localparam int SONG_LEN    = 100;
    localparam int NUM_LANES   = 3;
    localparam int LANE_RED    = 0;
    localparam int LANE_BLUE   = 1;
    localparam int LANE_YELLOW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Increment an 8-bit counter, sticking at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Add 1 or 2 points to the 16-bit score, sticking at 16'hFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/note_scroller_beat_divider.sv
// Beat divider: counts 0..BEAT_DIV-1 while enabled and flags the last count
// as the beat tick. 'clear' restarts the count from zero.
module beat_divider #(
    parameter int BEAT_DIV = 12500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(BEAT_DIV);
    localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running modulo-BEAT_DIV counter, advanced only while enabled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/note_scroller.sv
// Note scroller: three-lane rhythm-game chart player. Each lane is a 100-bit
// shift register whose MSB is the hit position; a key rising edge on a lane
// with a note at the MSB scores a hit, otherwise a miss. Notes still at the
// MSB when the beat shifts them out count as misses.
// Optional feature macro: NOTE_SCROLLER_COMBO_BONUS_EN (hits made with a
// combo of 10 or more score 2 points instead of 1).
// dbg_state exposes the FSM state for observation.
module note_scroller
    import note_pkg::*;
#(
    parameter int BEAT_DIV = 12500000,
    parameter int WINDOW   = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [SONG_LEN-1:0] song_red,
    input  logic [SONG_LEN-1:0] song_blue,
    input  logic [SONG_LEN-1:0] song_yellow,
    input  logic                key_red,
    input  logic                key_blue,
    input  logic                key_yellow,
    output logic [WINDOW-1:0]   win_red,
    output logic [WINDOW-1:0]   win_blue,
    output logic [WINDOW-1:0]   win_yellow,
    output logic                beat_tick,
    output logic                playing,
    output logic                done,
    output logic [15:0]         score,
    output logic [7:0]          combo,
    output logic [7:0]          misses,
    output logic [1:0]          dbg_state
);

    state_t                 r_state;
    logic [SONG_LEN-1:0]    r_lane [NUM_LANES];
    logic [NUM_LANES-1:0]   r_key_q;
    logic [6:0]             r_beat_cnt;
    logic [15:0]            r_score;
    logic [7:0]             r_combo;
    logic [7:0]             r_misses;
    logic                   r_playing;
    logic                   r_done;

    logic [NUM_LANES-1:0]   w_key;
    logic [NUM_LANES-1:0]   w_edge;
    logic [NUM_LANES-1:0]   w_head;
    logic [NUM_LANES-1:0]   w_hit;
    logic [NUM_LANES-1:0]   w_miss_ev;
    logic [15:0]            w_score_n;
    logic [7:0]             w_combo_n;
    logic [7:0]             w_misses_n;
    logic [1:0]             w_pts;
    logic                   w_tick;
    logic                   w_div_clear;
    logic                   w_div_en;

    assign w_key       = {key_yellow, key_blue, key_red};
    assign w_div_clear = (r_state == ST_LOAD);
    assign w_div_en    = (r_state == ST_PLAY);

    beat_divider #(.BEAT_DIV(BEAT_DIV)) u_beat_divider (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_div_clear),
        .enable (w_div_en),
        .tick   (w_tick)
    );

    // Judge key edges against the pre-shift hit position; a hit cancels expiry.
    always_comb begin
        w_edge = w_key & ~r_key_q & {NUM_LANES{r_state == ST_PLAY}};
        w_head = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_head[i] = r_lane[i][SONG_LEN-1];
        end
        w_hit     = w_edge & w_head;
        w_miss_ev = (w_edge & ~w_head) | ({NUM_LANES{w_tick}} & w_head & ~w_edge);
    end

    // Next score/combo/misses: all hits in lane order first, then all misses.
    always_comb begin
        w_score_n  = r_score;
        w_combo_n  = r_combo;
        w_misses_n = r_misses;
        w_pts      = 2'd1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_hit[i]) begin
`ifdef NOTE_SCROLLER_COMBO_BONUS_EN
                w_pts = (w_combo_n >= 8'd10) ? 2'd2 : 2'd1;
`else
                w_pts = 2'd1;
`endif
                w_score_n = sat_add16(w_score_n, w_pts);
                w_combo_n = sat_inc8(w_combo_n);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_miss_ev[i]) begin
                w_misses_n = sat_inc8(w_misses_n);
            end
        end
        if (|w_miss_ev) begin
            w_combo_n = '0;
        end
    end

    // Control FSM with lane registers, beat count, key history and scoring.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lane[i] <= '0;
            end
            r_key_q    <= '0;
            r_beat_cnt <= '0;
            r_score    <= '0;
            r_combo    <= '0;
            r_misses   <= '0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_key_q <= w_key;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_lane[LANE_RED]    <= song_red;
                    r_lane[LANE_BLUE]   <= song_blue;
                    r_lane[LANE_YELLOW] <= song_yellow;
                    r_beat_cnt <= '0;
                    r_score    <= '0;
                    r_combo    <= '0;
                    r_misses   <= '0;
                    r_playing  <= 1'b1;
                    r_state    <= ST_PLAY;
                end
                ST_PLAY: begin
                    r_score  <= w_score_n;
                    r_combo  <= w_combo_n;
                    r_misses <= w_misses_n;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (w_tick) begin
                            r_lane[i] <= r_lane[i] << 1;
                        end else if (w_hit[i]) begin
                            r_lane[i][SONG_LEN-1] <= 1'b0;
                        end
                    end
                    if (w_tick) begin
                        r_beat_cnt <= r_beat_cnt + 7'd1;
                        if (r_beat_cnt == 7'd99) begin
                            r_state   <= ST_DONE;
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign win_red    = r_lane[LANE_RED][SONG_LEN-1 -: WINDOW];
    assign win_blue   = r_lane[LANE_BLUE][SONG_LEN-1 -: WINDOW];
    assign win_yellow = r_lane[LANE_YELLOW][SONG_LEN-1 -: WINDOW];
    assign beat_tick  = w_tick;
    assign playing    = r_playing;
    assign done       = r_done;
    assign score      = r_score;
    assign combo      = r_combo;
    assign misses     = r_misses;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller with BEAT_DIV=4: tick timing, hits,
// coincident press, empty-lane press, mid-play reset and combo scoring.
module tb_note_scroller;
    import note_pkg::*;

    localparam int BEAT_DIV = 4;
    localparam int WINDOW   = 16;
`ifdef NOTE_SCROLLER_COMBO_BONUS_EN
    localparam int EXP_COMBO_SCORE = 14;
`else
    localparam int EXP_COMBO_SCORE = 12;
`endif

    logic                clk;
    logic                resetn;
    logic                start;
    logic [SONG_LEN-1:0] song_red, song_blue, song_yellow;
    logic                key_red, key_blue, key_yellow;
    logic [WINDOW-1:0]   win_red, win_blue, win_yellow;
    logic                beat_tick, playing, done;
    logic [15:0]         score;
    logic [7:0]          combo, misses;
    logic [1:0]          dbg_state;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_vec;
    int          n_miss;

    note_scroller #(.BEAT_DIV(BEAT_DIV), .WINDOW(WINDOW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .song_red    (song_red),
        .song_blue   (song_blue),
        .song_yellow (song_yellow),
        .key_red     (key_red),
        .key_blue    (key_blue),
        .key_yellow  (key_yellow),
        .win_red     (win_red),
        .win_blue    (win_blue),
        .win_yellow  (win_yellow),
        .beat_tick   (beat_tick),
        .playing     (playing),
        .done        (done),
        .score       (score),
        .combo       (combo),
        .misses      (misses),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic count_until_done(output int ticks);
        ticks = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (beat_tick) ticks++;
            step();
        end
    endtask

    // Scoreboard
    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] got);
        logic [31:0] exp_v;
        string       tag;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", got);
            return;
        end
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        assert (got === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp_v);
        end
    endtask

    task automatic check_idle_zero(input string pfx);
        push_exp({pfx, "_score"}, 0);
        push_exp({pfx, "_combo"}, 0);
        push_exp({pfx, "_misses"}, 0);
        push_exp({pfx, "_beat_tick"}, 0);
        push_exp({pfx, "_playing"}, 0);
        push_exp({pfx, "_done"}, 0);
        push_exp({pfx, "_win_red"}, 0);
        push_exp({pfx, "_win_blue"}, 0);
        push_exp({pfx, "_win_yellow"}, 0);
        push_exp({pfx, "_state"}, 32'(ST_IDLE));
        check(32'(score));
        check(32'(combo));
        check(32'(misses));
        check(32'(beat_tick));
        check(32'(playing));
        check(32'(done));
        check(32'(win_red));
        check(32'(win_blue));
        check(32'(win_yellow));
        check(32'(dbg_state));
    endtask

    // Directed sequence
    initial begin
        int n;
        int m;
        int t;
        int ticks_seen;
        n_vec = 0;
        n_miss = 0;
        resetn = 1'b0;
        start = 1'b0;
        key_red = 1'b0;
        key_blue = 1'b0;
        key_yellow = 1'b0;
        song_red = '0;
        song_blue = '0;
        song_yellow = '0;
        step();
        step();
        check_idle_zero("rst");
        resetn = 1'b1;
        step();

        // Ticks: lone red note, no keys
        song_red = 100'h1 << 99;
        push_exp("t1_win_load", 32'h8000);
        push_exp("t1_playing", 1);
        push_exp("t1_first_tick_cycles", 4);
        push_exp("t1_misses_tick1", 1);
        push_exp("t1_combo_tick1", 0);
        push_exp("t1_win_tick1", 0);
        push_exp("t1_tick_period", 4);
        push_exp("t1_ticks_total", 100);
        push_exp("t1_done", 1);
        push_exp("t1_playing_end", 0);
        push_exp("t1_state_end", 32'(ST_DONE));
        push_exp("t1_score_end", 0);
        push_exp("t1_misses_end", 1);
        pulse_start();
        step();
        n = 1;
        check(32'(win_red));
        check(32'(playing));
        while (!beat_tick && n < 20) begin step(); n++; end
        check(32'(n));
        step();
        check(32'(misses));
        check(32'(combo));
        check(32'(win_red));
        m = 1;
        while (!beat_tick && m < 20) begin step(); m++; end
        check(32'(m));
        count_until_done(t);
        check(32'(t + 1));
        check(32'(done));
        check(32'(playing));
        check(32'(dbg_state));
        check(32'(score));
        check(32'(misses));

        // Hit: restart from DONE, press red before the first tick
        push_exp("t2_score_hit", 1);
        push_exp("t2_combo_hit", 1);
        push_exp("t2_win_hit", 0);
        push_exp("t2_start_ignored_playing", 1);
        push_exp("t2_start_ignored_state", 32'(ST_PLAY));
        push_exp("t2_done", 1);
        push_exp("t2_score_end", 1);
        push_exp("t2_combo_end", 1);
        push_exp("t2_misses_end", 0);
        pulse_start();
        step();
        key_red = 1'b1;
        step();
        check(32'(score));
        check(32'(combo));
        check(32'(win_red));
        key_red = 1'b0;
        step();
        step();
        pulse_start();
        step();
        check(32'(playing));
        check(32'(dbg_state));
        count_until_done(t);
        check(32'(done));
        check(32'(score));
        check(32'(combo));
        check(32'(misses));

        // Coincident press: note reaches hit position, press lands on tick 2
        song_red = 100'h1 << 98;
        push_exp("t3_tick_at_press", 1);
        push_exp("t3_win_at_press", 32'h8000);
        push_exp("t3_score", 1);
        push_exp("t3_combo", 1);
        push_exp("t3_misses", 0);
        push_exp("t3_win_after", 0);
        push_exp("t4_misses", 1);
        push_exp("t4_combo", 0);
        push_exp("t4_score", 1);
        pulse_start();
        repeat (8) step();
        check(32'(beat_tick));
        check(32'(win_red));
        key_red = 1'b1;
        step();
        check(32'(score));
        check(32'(combo));
        check(32'(misses));
        check(32'(win_red));
        // Empty-lane press on blue
        key_red = 1'b0;
        key_blue = 1'b1;
        step();
        check(32'(misses));
        check(32'(combo));
        check(32'(score));
        key_blue = 1'b0;

        // Reset mid-PLAY at beat 37
        push_exp("t5_playing_before", 1);
        ticks_seen = 2;
        for (int i = 0; i < 1000 && ticks_seen < 37; i++) begin
            step();
            if (beat_tick) ticks_seen++;
        end
        step();
        check(32'(playing));
        resetn = 1'b0;
        #1;
        check_idle_zero("t5");
        step();
        resetn = 1'b1;
        step();
        step();
        push_exp("t5_stays_idle", 32'(ST_IDLE));
        check(32'(dbg_state));
        song_red = 100'h1 << 99;
        push_exp("t5_win_reload", 32'h8000);
        push_exp("t5_ticks_replay", 100);
        push_exp("t5_misses_replay", 1);
        push_exp("t5_done_replay", 1);
        pulse_start();
        step();
        check(32'(win_red));
        count_until_done(t);
        check(32'(t));
        check(32'(misses));
        check(32'(done));

        // Combo: 12 consecutive red notes, each hit mid-beat
        song_red = 100'hFFF << 88;
        push_exp("t6_score", 32'(EXP_COMBO_SCORE));
        push_exp("t6_combo", 12);
        push_exp("t6_misses", 0);
        pulse_start();
        step();
        for (int k = 0; k < 12; k++) begin
            key_red = 1'b1;
            step();
            key_red = 1'b0;
            step();
            step();
            step();
        end
        count_until_done(t);
        check(32'(score));
        check(32'(combo));
        check(32'(misses));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
